// File: rtl/fpu_issue_queue.sv
// -----------------------------------------------------------------------------
// fpu_issue_queue
//
// Command buffer and sequencer placed directly in front of the FPU datapath.
// Commands arrive over a valid/ready handshake and are held in a DEPTH-entry
// FIFO. One command at a time is popped into the FPU operand registers and
// started. The FPU's registered result is captured one cycle after issue.
// The result is then returned with the command's tag over a valid/ready port.
// Results come back in command order, and only one command is in flight.
//
// Ports
//   clk, reset        clock; asynchronous active-low reset
//   cmd_*             command input handshake (operands, op select,
//                     rounding mode, user tag)
//   fpu_*  (out)      operand/select/rounding registers and start pulse to FPU
//   fpu_*  (in)       FPU registered result Y plus error/overflow flags
//   res_*             result output handshake (Y, flags, tag)
//   count             FIFO occupancy (commands waiting, excluding in-flight)
//   busy              sequencer not idle or FIFO not empty
// -----------------------------------------------------------------------------
module fpu_issue_queue #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  // command port
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [31:0]            cmd_a,
  input  logic [31:0]            cmd_b,
  input  logic [1:0]             cmd_sel,
  input  logic [1:0]             cmd_rmode,
  input  logic [TAG_W-1:0]       cmd_tag,
  // FPU drive
  output logic [31:0]            fpu_a,
  output logic [31:0]            fpu_b,
  output logic [1:0]             fpu_sel,
  output logic [1:0]             fpu_rmode,
  output logic                   fpu_start,
  // FPU result
  input  logic [31:0]            fpu_y,
  input  logic                   fpu_error,
  input  logic                   fpu_overflow,
  // result port
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [31:0]            res_y,
  output logic                   res_error,
  output logic                   res_overflow,
  output logic [TAG_W-1:0]       res_tag,
  // status
  output logic [$clog2(DEPTH):0] count,
  output logic                   busy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [31:0]      a;
    logic [31:0]      b;
    logic [1:0]       sel;
    logic [1:0]       rmode;
    logic [TAG_W-1:0] tag;
  } cmd_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  cmd_t             mem [DEPTH];
  cmd_t             cmd_in;
  cmd_t             head;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [TAG_W-1:0] pend_tag;
  state_t           state;
  logic             push;
  logic             pop;
  logic             fifo_nonempty;

  assign cmd_in = '{a: cmd_a, b: cmd_b, sel: cmd_sel, rmode: cmd_rmode, tag: cmd_tag};
  assign head   = mem[rd_ptr];

  // Ready depends only on the registered count. A pop in the same cycle
  // does not free a slot early, so res_ready has no path to cmd_ready.
  assign cmd_ready     = (count < CNT_W'(DEPTH));
  assign push          = cmd_valid && cmd_ready;
  assign fifo_nonempty = (count != '0);
  assign busy          = (state != IDLE) || fifo_nonempty;

  // The head is popped when the sequencer is free. That happens either from
  // IDLE or on the edge where the current result is accepted. A command
  // pushed this cycle is not yet counted, so it cannot be popped until the
  // next edge.
  always_comb begin
    // NOTE: every signal written in always_comb gets a default first so that
    // no path leaves it unassigned (which would infer a latch).
    pop = 1'b0;
    case (state)
      IDLE:    pop = fifo_nonempty;
      RESP:    pop = res_valid && res_ready && fifo_nonempty;
      default: pop = 1'b0;
    endcase
  end

  // NOTE: the command storage is deliberately not reset. Validity is tracked
  // by the pointers and count, so clearing the array would only add reset
  // fan-out with no functional effect.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= cmd_in;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // DEPTH is a power of two, so natural pointer overflow wraps modulo DEPTH.
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Sequencer: IDLE -> ISSUE (start pulse) -> WAIT (FPU computing) -> RESP.
  // The FPU registers its result at the end of ISSUE, so the capture happens
  // on the edge that leaves WAIT.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      fpu_a        <= '0;
      fpu_b        <= '0;
      fpu_sel      <= '0;
      fpu_rmode    <= '0;
      fpu_start    <= 1'b0;
      pend_tag     <= '0;
      res_valid    <= 1'b0;
      res_y        <= '0;
      res_error    <= 1'b0;
      res_overflow <= 1'b0;
      res_tag      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            fpu_a     <= head.a;
            fpu_b     <= head.b;
            fpu_sel   <= head.sel;
            fpu_rmode <= head.rmode;
            pend_tag  <= head.tag;
            fpu_start <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          fpu_start <= 1'b0;
          state     <= WAIT;
        end
        WAIT: begin
          res_y        <= fpu_y;
          res_error    <= fpu_error;
          res_overflow <= fpu_overflow;
          res_tag      <= pend_tag;
          res_valid    <= 1'b1;
          state        <= RESP;
        end
        RESP: begin
          // The result holds while the consumer stalls.
          if (res_ready) begin
            res_valid <= 1'b0;
            if (pop) begin
              fpu_a     <= head.a;
              fpu_b     <= head.b;
              fpu_sel   <= head.sel;
              fpu_rmode <= head.rmode;
              pend_tag  <= head.tag;
              fpu_start <= 1'b1;
              state     <= ISSUE;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          fpu_start <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_issue_queue.sv
// -----------------------------------------------------------------------------
// tb_fpu_issue_queue
//
// Self-checking bench for fpu_issue_queue. A stand-in FPU registers a result
// one cycle after start and drives noise on every other cycle.
//
// The reference model works at transaction level. It keeps a queue of stored
// commands and counts the cycles since the current command was issued. It
// predicts occupancy, handshakes, the start pulse and the returned results.
// Directed sequences cover:
//   - latency
//   - passthrough of the FPU flags
//   - backpressure
//   - a simultaneous push and pop
//   - reset in the middle of an operation
// A randomized stream checks pointer wrap and in-order return.
// -----------------------------------------------------------------------------
module tb_fpu_issue_queue;

  localparam int DEPTH = 4;
  localparam int TAG_W = 4;
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int N_RAND = 40;

  typedef struct packed {
    logic [31:0]      a;
    logic [31:0]      b;
    logic [1:0]       sel;
    logic [1:0]       rmode;
    logic [TAG_W-1:0] tag;
  } cmd_t;

  typedef struct {
    cmd_t        c;
    logic [31:0] y;
    logic        err;
    logic        ovf;
  } vec_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [31:0]      cmd_a;
  logic [31:0]      cmd_b;
  logic [1:0]       cmd_sel;
  logic [1:0]       cmd_rmode;
  logic [TAG_W-1:0] cmd_tag;
  logic [31:0]      fpu_a;
  logic [31:0]      fpu_b;
  logic [1:0]       fpu_sel;
  logic [1:0]       fpu_rmode;
  logic             fpu_start;
  logic [31:0]      fpu_y;
  logic             fpu_error;
  logic             fpu_overflow;
  logic             res_valid;
  logic             res_ready;
  logic [31:0]      res_y;
  logic             res_error;
  logic             res_overflow;
  logic [TAG_W-1:0] res_tag;
  logic [CNT_W-1:0] count;
  logic             busy;

  always #5 clk = ~clk;

  fpu_issue_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_a        (cmd_a),
    .cmd_b        (cmd_b),
    .cmd_sel      (cmd_sel),
    .cmd_rmode    (cmd_rmode),
    .cmd_tag      (cmd_tag),
    .fpu_a        (fpu_a),
    .fpu_b        (fpu_b),
    .fpu_sel      (fpu_sel),
    .fpu_rmode    (fpu_rmode),
    .fpu_start    (fpu_start),
    .fpu_y        (fpu_y),
    .fpu_error    (fpu_error),
    .fpu_overflow (fpu_overflow),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_y        (res_y),
    .res_error    (res_error),
    .res_overflow (res_overflow),
    .res_tag      (res_tag),
    .count        (count),
    .busy         (busy)
  );

  // ---------------------------------------------------------------------------
  // FPU behaviour. It returns fixed answers for the directed operands.
  // Any other input gets a deterministic mix of the operands, select and
  // rounding mode, so a corrupted field shows up in the result.
  // Returns {y, error, overflow}.
  // ---------------------------------------------------------------------------
  function automatic logic [33:0] fpu_ref(input logic [31:0] a, input logic [31:0] b,
                                          input logic [1:0] sel, input logic [1:0] rmode);
    logic [31:0] y;
    if (sel == 2'b00 && a == 32'h3F80_0000 && b == 32'h4000_0000)
      return {32'h4040_0000, 1'b0, 1'b0};
    if (sel == 2'b10 && a == 32'h7F7F_FFFF && b == 32'h4000_0000)
      return {32'h7F80_0000, 1'b0, 1'b1};
    if (sel == 2'b11 && b[30:0] == 31'h0)
      return {a[31] ^ b[31], 8'hFF, 23'h0, 1'b1, 1'b0};
    y = (a ^ {b[15:0], b[31:16]}) + {28'h0, sel, rmode};
    return {y, a[0] ^ b[0], a[1] & b[1]};
  endfunction

  // The result is valid only in the cycle after start. At all other times the
  // FPU outputs noise, so a capture on the wrong cycle is visible.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      fpu_y        <= '0;
      fpu_error    <= 1'b0;
      fpu_overflow <= 1'b0;
    end else if (fpu_start) begin
      {fpu_y, fpu_error, fpu_overflow} <= fpu_ref(fpu_a, fpu_b, fpu_sel, fpu_rmode);
    end else begin
      fpu_y        <= $urandom;
      fpu_error    <= 1'($urandom);
      fpu_overflow <= 1'($urandom);
    end
  end

  // ---------------------------------------------------------------------------
  // Reference model state
  //   mq       commands stored and not yet issued
  //   ph       cycles since the current command was issued
  //            (0 = nothing in flight, 1 = start, 2 = computing,
  //             3 = result offered)
  //   cur      command in flight
  //   retired  tags of results accepted by the consumer, in order
  // ---------------------------------------------------------------------------
  cmd_t             mq[$];
  int               ph;
  cmd_t             cur;
  logic [TAG_W-1:0] retired[$];
  int               retire_cyc[$];
  logic [TAG_W-1:0] acc_tags[$];
  int               cyc;
  bit               accepted;
  int               n_vec;
  int               n_bad;
  vec_t             tbl[4];
  bit               found;
  cmd_t             xs[4];
  int               seq;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic cmd_t mkcmd(input logic [31:0] a, input logic [31:0] b,
                                 input logic [1:0] sel, input logic [1:0] rmode,
                                 input logic [TAG_W-1:0] tag);
    cmd_t c;
    c.a = a; c.b = b; c.sel = sel; c.rmode = rmode; c.tag = tag;
    return c;
  endfunction

  function automatic cmd_t rndcmd(input logic [TAG_W-1:0] tag);
    return mkcmd($urandom, $urandom, 2'($urandom), 2'($urandom), tag);
  endfunction

  task automatic drive_cmd(input cmd_t c, input bit v);
    cmd_valid = v;
    cmd_a     = c.a;
    cmd_b     = c.b;
    cmd_sel   = c.sel;
    cmd_rmode = c.rmode;
    cmd_tag   = c.tag;
  endtask

  // Compare every observable output against the model.
  task automatic compare_all();
    logic [33:0] r;
    check("count", 64'(count), 64'(mq.size()));
    check("cmd_ready", 64'(cmd_ready), 64'(mq.size() < DEPTH));
    check("fpu_start", 64'(fpu_start), 64'(ph == 1));
    check("res_valid", 64'(res_valid), 64'(ph == 3));
    check("busy", 64'(busy), 64'(ph != 0 || mq.size() != 0));
    if (ph != 0) begin
      check("fpu_a", 64'(fpu_a), 64'(cur.a));
      check("fpu_b", 64'(fpu_b), 64'(cur.b));
      check("fpu_sel", 64'(fpu_sel), 64'(cur.sel));
      check("fpu_rmode", 64'(fpu_rmode), 64'(cur.rmode));
    end
    if (ph == 3) begin
      r = fpu_ref(cur.a, cur.b, cur.sel, cur.rmode);
      check("res_y", 64'(res_y), 64'(r[33:2]));
      check("res_error", 64'(res_error), 64'(r[1]));
      check("res_overflow", 64'(res_overflow), 64'(r[0]));
      check("res_tag", 64'(res_tag), 64'(cur.tag));
    end
  endtask

  // Advance the model by one edge using the inputs driven now. Then clock
  // the DUT and compare. The model pops from the queue before it pushes,
  // so a command written on this edge cannot issue on this edge.
  task automatic tick();
    int   sz;
    cmd_t c;
    sz       = mq.size();
    accepted = 1'b0;
    case (ph)
      0: if (sz > 0) begin cur = mq.pop_front(); ph = 1; end
      1: ph = 2;
      2: ph = 3;
      3: if (res_ready) begin
           retired.push_back(cur.tag);
           retire_cyc.push_back(cyc + 1);
           if (sz > 0) begin cur = mq.pop_front(); ph = 1; end
           else ph = 0;
         end
      default: ph = 0;
    endcase
    if (cmd_valid && sz < DEPTH) begin
      c = mkcmd(cmd_a, cmd_b, cmd_sel, cmd_rmode, cmd_tag);
      mq.push_back(c);
      accepted = 1'b1;
    end
    @(posedge clk);
    #1;
    cyc++;
    compare_all();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    // Directed vectors: operands, then the answer the FPU gives for them.
    tbl[0].c = mkcmd(32'h3F80_0000, 32'h4000_0000, 2'b00, 2'b00, 4'd3);
    tbl[0].y = 32'h4040_0000; tbl[0].err = 1'b0; tbl[0].ovf = 1'b0;
    tbl[1].c = mkcmd(32'h7F7F_FFFF, 32'h4000_0000, 2'b10, 2'b01, 4'd5);
    tbl[1].y = 32'h7F80_0000; tbl[1].err = 1'b0; tbl[1].ovf = 1'b1;
    tbl[2].c = mkcmd(32'h3F80_0000, 32'h0000_0000, 2'b11, 2'b10, 4'd6);
    tbl[2].y = 32'h7F80_0000; tbl[2].err = 1'b1; tbl[2].ovf = 1'b0;
    tbl[3].c = mkcmd(32'hBF80_0000, 32'h0000_0000, 2'b11, 2'b11, 4'd7);
    tbl[3].y = 32'hFF80_0000; tbl[3].err = 1'b1; tbl[3].ovf = 1'b0;

    n_vec = 0; n_bad = 0; cyc = 0; ph = 0;
    reset = 1'b0;
    res_ready = 1'b0;
    drive_cmd(mkcmd('0, '0, '0, '0, '0), 1'b0);

    // ---- reset values ----
    #12;
    check("rst_count", 64'(count), 64'd0);
    check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_fpu_start", 64'(fpu_start), 64'd0);
    check("rst_fpu_a", 64'(fpu_a), 64'd0);
    check("rst_fpu_b", 64'(fpu_b), 64'd0);
    check("rst_fpu_sel", 64'(fpu_sel), 64'd0);
    check("rst_fpu_rmode", 64'(fpu_rmode), 64'd0);
    check("rst_res_valid", 64'(res_valid), 64'd0);
    check("rst_res_y", 64'(res_y), 64'd0);
    check("rst_res_error", 64'(res_error), 64'd0);
    check("rst_res_overflow", 64'(res_overflow), 64'd0);
    check("rst_res_tag", 64'(res_tag), 64'd0);
    @(negedge clk) reset = 1'b1;
    @(posedge clk);
    #1;

    // ---- single add: latency and start pulse width ----
    res_ready = 1'b1;
    drive_cmd(tbl[0].c, 1'b1);
    tick();                                   // push edge t0
    cmd_valid = 1'b0;
    check("add_t0_start", 64'(fpu_start), 64'd0);
    check("add_t0_count", 64'(count), 64'd1);
    tick();                                   // t1: issue
    check("add_t1_start", 64'(fpu_start), 64'd1);
    tick();                                   // t2
    check("add_t2_start", 64'(fpu_start), 64'd0);
    check("add_t2_res_valid", 64'(res_valid), 64'd0);
    tick();                                   // t3: result
    check("add_t3_res_valid", 64'(res_valid), 64'd1);
    check("add_t3_res_y", 64'(res_y), 64'h4040_0000);
    check("add_t3_res_tag", 64'(res_tag), 64'd3);
    check("add_t3_err", 64'(res_error), 64'd0);
    check("add_t3_ovf", 64'(res_overflow), 64'd0);
    tick();                                   // t4: accepted
    check("add_t4_res_valid", 64'(res_valid), 64'd0);
    check("add_t4_busy", 64'(busy), 64'd0);

    // ---- table-driven flag passthrough ----
    for (int i = 0; i < 4; i++) begin
      drive_cmd(tbl[i].c, 1'b1);
      tick();
      cmd_valid = 1'b0;
      found = 1'b0;
      for (int k = 0; k < 8 && !found; k++) begin
        if (res_valid) found = 1'b1;
        else tick();
      end
      check($sformatf("vec%0d_seen", i), 64'(found), 64'd1);
      check($sformatf("vec%0d_y", i), 64'(res_y), 64'(tbl[i].y));
      check($sformatf("vec%0d_err", i), 64'(res_error), 64'(tbl[i].err));
      check($sformatf("vec%0d_ovf", i), 64'(res_overflow), 64'(tbl[i].ovf));
      check($sformatf("vec%0d_tag", i), 64'(res_tag), 64'(tbl[i].c.tag));
      tick();
    end

    // ---- fill and backpressure ----
    res_ready = 1'b0;
    retired.delete();
    retire_cyc.delete();
    for (int t = 0; t < 5; t++) begin
      drive_cmd(rndcmd(TAG_W'(t)), 1'b1);
      tick();
    end
    check("fill_count", 64'(count), 64'd4);
    check("fill_cmd_ready", 64'(cmd_ready), 64'd0);
    drive_cmd(rndcmd(4'd9), 1'b1);            // ignored while full
    tick();
    tick();
    cmd_valid = 1'b0;
    check("full_ignored_count", 64'(count), 64'd4);
    check("stall_res_valid", 64'(res_valid), 64'd1);
    check("stall_res_tag", 64'(res_tag), 64'd0);
    res_ready = 1'b1;
    for (int k = 0; k < 40 && retired.size() < 5; k++) tick();
    check("fill_retired_n", 64'(retired.size()), 64'd5);
    for (int i = 0; i < retired.size(); i++)
      check($sformatf("fill_order%0d", i), 64'(retired[i]), 64'(i));
    for (int i = 1; i < retire_cyc.size(); i++)
      check($sformatf("fill_spacing%0d", i), 64'(retire_cyc[i] - retire_cyc[i-1]), 64'd3);

    // ---- simultaneous push and pop in RESP with count=2 ----
    retired.delete();
    for (int i = 0; i < 4; i++) xs[i] = rndcmd(TAG_W'(10 + i));
    res_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_cmd(xs[i], 1'b1);
      tick();
    end
    cmd_valid = 1'b0;
    tick();
    check("pp_pre_count", 64'(count), 64'd2);
    check("pp_pre_res_valid", 64'(res_valid), 64'd1);
    drive_cmd(xs[3], 1'b1);
    res_ready = 1'b1;
    tick();
    cmd_valid = 1'b0;
    check("pp_count", 64'(count), 64'd2);
    check("pp_start", 64'(fpu_start), 64'd1);
    check("pp_fpu_a", 64'(fpu_a), 64'(xs[1].a));
    for (int k = 0; k < 40 && retired.size() < 4; k++) tick();
    check("pp_retired_n", 64'(retired.size()), 64'd4);
    for (int i = 0; i < retired.size(); i++)
      check($sformatf("pp_order%0d", i), 64'(retired[i]), 64'(10 + i));

    // ---- reset while in WAIT with count=3 ----
    res_ready = 1'b0;
    for (int t = 0; t < 5; t++) begin
      drive_cmd(rndcmd(TAG_W'(1 + t)), 1'b1);
      tick();
    end
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    tick();                                   // result taken, next command issues
    res_ready = 1'b0;
    tick();                                   // now computing, three queued
    check("mid_pre_count", 64'(count), 64'd3);
    check("mid_pre_ph", 64'(ph), 64'd2);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_start", 64'(fpu_start), 64'd0);
    check("mid_rst_res_valid", 64'(res_valid), 64'd0);
    check("mid_rst_count", 64'(count), 64'd0);
    check("mid_rst_cmd_ready", 64'(cmd_ready), 64'd1);
    mq.delete();
    ph = 0;
    @(negedge clk) reset = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b1;
    for (int k = 0; k < 6; k++) tick();
    check("post_rst_res_valid", 64'(res_valid), 64'd0);
    check("post_rst_busy", 64'(busy), 64'd0);

    // ---- randomized stream: wrap, backpressure, in-order return ----
    retired.delete();
    acc_tags.delete();
    seq = 0;
    for (int k = 0; k < 3000 && (seq < N_RAND || retired.size() < N_RAND); k++) begin
      drive_cmd(rndcmd(TAG_W'(seq)), (seq < N_RAND) && ($urandom_range(0, 3) != 0));
      res_ready = 1'($urandom);
      tick();
      if (accepted) begin
        acc_tags.push_back(TAG_W'(seq));
        seq++;
      end
    end
    cmd_valid = 1'b0;
    check("rand_accepted_n", 64'(acc_tags.size()), 64'(N_RAND));
    check("rand_retired_n", 64'(retired.size()), 64'(N_RAND));
    for (int i = 0; i < retired.size() && i < acc_tags.size(); i++)
      check($sformatf("rand_order%0d", i), 64'(retired[i]), 64'(acc_tags[i]));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
